// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped write-back / write-allocate data cache controller
//               sequencing lookup, dirty-line writeback and line refill.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 6,
    parameter int CACHE_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_byte_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_valid,
    input  logic [31:0]           mem_rd_data,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  mem_wr_last,
    input  logic                  mem_wr_ready
);

    localparam int c_WORD_W = LINE_WIDTH - 2;
    localparam int c_TAG_W  = ADDR_WIDTH - LINE_WIDTH - CACHE_WIDTH;
    localparam int c_PTR_W  = CACHE_WIDTH + c_WORD_W;
    localparam int c_LINES  = 2 ** CACHE_WIDTH;
    localparam int c_DEPTH  = 2 ** c_PTR_W;
    localparam logic [c_WORD_W-1:0] c_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [31:0]              r_data    [c_DEPTH];
    logic [c_TAG_W-1:0]       r_tag_mem [c_LINES];
    logic [c_LINES-1:0]       r_valid;
    logic [c_LINES-1:0]       r_dirty;
    logic [c_TAG_W-1:0]       r_tag;
    logic [CACHE_WIDTH-1:0]   r_index;
    logic [c_WORD_W-1:0]      r_word;
    logic [c_WORD_W-1:0]      r_cnt;
    logic                     r_we;
    logic [3:0]               r_be;
    logic [31:0]              r_wdata;

    logic [c_TAG_W-1:0]       w_tag;
    logic [CACHE_WIDTH-1:0]   w_index;
    logic [c_WORD_W-1:0]      w_word;
    logic [c_PTR_W-1:0]       w_cur_ptr;
    logic [c_PTR_W-1:0]       w_line_ptr;
    logic [c_PTR_W-1:0]       w_done_ptr;
    logic                     w_hit;
    logic                     w_rd_beat;
    logic                     w_rd_last;
    logic                     w_unused;

    assign w_tag      = cpu_addr[ADDR_WIDTH-1 -: c_TAG_W];
    assign w_index    = cpu_addr[LINE_WIDTH +: CACHE_WIDTH];
    assign w_word     = cpu_addr[2 +: c_WORD_W];
    assign w_unused   = ^cpu_addr[1:0];
    assign w_cur_ptr  = {w_index, w_word};
    assign w_line_ptr = {r_index, r_cnt};
    assign w_done_ptr = {r_index, r_word};

    assign w_hit     = (r_state == S_IDLE) && cpu_en && r_valid[w_index]
                       && (r_tag_mem[w_index] == w_tag);
    assign w_rd_beat = (r_state == S_REFILL) && mem_rd_valid;
    assign w_rd_last = w_rd_beat && (r_cnt == c_LAST);

    assign cpu_ready   = w_hit || (r_state == S_DONE);
    assign mem_rd_req  = (r_state == S_REFILL);
    assign mem_wr_req  = (r_state == S_WB);
    assign mem_wr_last = (r_state == S_WB) && (r_cnt == c_LAST);
    assign mem_rd_addr = (r_state == S_REFILL) ? {r_tag, r_index, {LINE_WIDTH{1'b0}}} : '0;
    assign mem_wr_addr = (r_state == S_WB)
                         ? {r_tag_mem[r_index], r_index, {LINE_WIDTH{1'b0}}} : '0;
    assign mem_wr_data = (r_state == S_WB) ? r_data[w_line_ptr] : '0;

    always_comb begin
        cpu_rdata = '0;
        if (w_hit && !cpu_we)
            cpu_rdata = r_data[w_cur_ptr];
        else if ((r_state == S_DONE) && !r_we)
            cpu_rdata = r_data[w_done_ptr];
    end

    // Line storage: store hit, refill beat and post-refill store merge never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_hit && cpu_we) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_byte_en[b])
                        r_data[w_cur_ptr][8*b +: 8] <= cpu_wdata[8*b +: 8];
            end else if (w_rd_beat) begin
                r_data[w_line_ptr] <= mem_rd_data;
            end else if ((r_state == S_DONE) && r_we) begin
                for (int b = 0; b < 4; b++)
                    if (r_be[b])
                        r_data[w_done_ptr][8*b +: 8] <= r_wdata[8*b +: 8];
            end
            if (w_rd_last)
                r_tag_mem[r_index] <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_index <= '0;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        if (cpu_we)
                            r_dirty[w_index] <= 1'b1;
                    end else if (cpu_en) begin
                        r_tag   <= w_tag;
                        r_index <= w_index;
                        r_word  <= w_word;
                        r_we    <= cpu_we;
                        r_be    <= cpu_byte_en;
                        r_wdata <= cpu_wdata;
                        r_cnt   <= '0;
                        r_state <= (r_valid[w_index] && r_dirty[w_index]) ? S_WB : S_REFILL;
                    end
                end
                S_WB: begin
                    if (mem_wr_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST)
                            r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_rd_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_valid[r_index] <= 1'b1;
                            r_dirty[r_index] <= 1'b0;
                            r_state          <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_we)
                        r_dirty[r_index] <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl against a transparent-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_en = 1'b0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_byte_en = '0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_last;
    logic        mem_wr_ready = 1'b0;

    dcache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_we       (cpu_we),
        .cpu_byte_en  (cpu_byte_en),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_last  (mem_wr_last),
        .mem_wr_ready (mem_wr_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // What the CPU should observe (view) and what external memory holds (back).
    logic [31:0] view [int unsigned];
    logic [31:0] back [int unsigned];
    bit          m_valid [64];
    bit          m_dirty [64];
    logic [19:0] m_tag   [64];

    int          rd_beat;
    int          wr_beat;
    logic [31:0] exp_rd_addr;
    logic [31:0] exp_wr_addr;
    bit          wr_toggle = 1'b0;

    function automatic int unsigned key(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        if (a[31:6] == 26'h41)
            return {28'd0, a[5:2]};
        return {a[31:2], 2'b00} ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] back_rd(input logic [31:0] a);
        if (back.exists(key(a)))
            return back[key(a)];
        return mem_default(a);
    endfunction

    function automatic logic [31:0] view_rd(input logic [31:0] a);
        if (view.exists(key(a)))
            return view[key(a)];
        return back_rd(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        view.delete();
    endtask

    task automatic mem_drive();
        if (wr_toggle)
            mem_wr_ready = !mem_wr_ready;
        else
            mem_wr_ready = ($urandom_range(0, 3) != 0);
        if (mem_wr_req)
            mem_rd_valid = 1'b1;
        else
            mem_rd_valid = ($urandom_range(0, 3) != 0);
        if (mem_rd_req && mem_rd_valid)
            mem_rd_data = back_rd(exp_rd_addr + 32'(rd_beat) * 32'd4);
        else
            mem_rd_data = $urandom;
    endtask

    task automatic mem_check();
        logic [31:0] a;
        if (mem_rd_req || mem_wr_req) begin
            n_checks++;
            if (cpu_ready !== 1'b0)
                $display("FAIL ready_during_burst: got %b expected 0", cpu_ready);
            else
                n_pass++;
        end
        if (mem_rd_req) begin
            n_checks++;
            if (mem_rd_addr !== exp_rd_addr)
                $display("FAIL rd_addr: got %h expected %h", mem_rd_addr, exp_rd_addr);
            else
                n_pass++;
            if (mem_rd_valid && rst)
                rd_beat++;
        end
        if (mem_wr_req) begin
            a = exp_wr_addr + 32'(wr_beat) * 32'd4;
            n_checks++;
            if (mem_wr_addr !== exp_wr_addr)
                $display("FAIL wr_addr: got %h expected %h", mem_wr_addr, exp_wr_addr);
            else
                n_pass++;
            n_checks++;
            if (mem_wr_data !== view_rd(a))
                $display("FAIL wr_data beat %0d: got %h expected %h", wr_beat, mem_wr_data, view_rd(a));
            else
                n_pass++;
            n_checks++;
            if (mem_wr_last !== (wr_beat == 15))
                $display("FAIL wr_last beat %0d: got %b expected %b", wr_beat, mem_wr_last, wr_beat == 15);
            else
                n_pass++;
            if (mem_wr_ready && rst) begin
                back[key(a)] = view_rd(a);
                wr_beat++;
            end
        end
    endtask

    task automatic access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input string nm);
        int          idx;
        bit          exp_hit;
        bit          exp_wb;
        logic [31:0] exp_data;
        logic [31:0] w;
        int          cycles;
        bit          got;
        idx      = int'(addr[11:6]);
        exp_hit  = m_valid[idx] && (m_tag[idx] == addr[31:12]);
        exp_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
        exp_data = view_rd(addr);
        exp_rd_addr = {addr[31:6], 6'b0};
        exp_wr_addr = {m_tag[idx], addr[11:6], 6'b0};
        rd_beat = 0;
        wr_beat = 0;
        cycles  = 0;
        got     = 1'b0;
        @(negedge clk);
        cpu_en      = 1'b1;
        cpu_we      = we;
        cpu_byte_en = be;
        cpu_addr    = addr;
        cpu_wdata   = wdata;
        while (!got && cycles < 300) begin
            mem_drive();
            #1;
            mem_check();
            if (cpu_ready === 1'b1)
                got = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
        n_checks++;
        if (!got) begin
            $display("FAIL %s timeout: got no cpu_ready expected cpu_ready within 300 cycles", nm);
            return;
        end
        n_pass++;
        n_checks++;
        if ((cycles == 0) !== exp_hit)
            $display("FAIL %s hit_latency: got %0d wait cycles expected hit=%b", nm, cycles, exp_hit);
        else
            n_pass++;
        n_checks++;
        if (wr_beat !== (exp_wb ? 16 : 0))
            $display("FAIL %s wb_beats: got %0d expected %0d", nm, wr_beat, exp_wb ? 16 : 0);
        else
            n_pass++;
        n_checks++;
        if (rd_beat !== (exp_hit ? 0 : 16))
            $display("FAIL %s refill_beats: got %0d expected %0d", nm, rd_beat, exp_hit ? 0 : 16);
        else
            n_pass++;
        if (!we) begin
            n_checks++;
            if (cpu_rdata !== exp_data)
                $display("FAIL %s rdata: got %h expected %h", nm, cpu_rdata, exp_data);
            else
                n_pass++;
        end else begin
            w = view_rd(addr);
            for (int b = 0; b < 4; b++)
                if (be[b])
                    w[8*b +: 8] = wdata[8*b +: 8];
            view[key(addr)] = w;
        end
        if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[31:12];
            m_dirty[idx] = we;
        end else if (we) begin
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (cpu_ready !== 1'b0) $display("FAIL reset_cpu_ready: got %b expected 0", cpu_ready); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'd0) $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); else n_pass++;
        n_checks++; if (mem_rd_req !== 1'b0) $display("FAIL reset_rd_req: got %b expected 0", mem_rd_req); else n_pass++;
        n_checks++; if (mem_wr_req !== 1'b0) $display("FAIL reset_wr_req: got %b expected 0", mem_wr_req); else n_pass++;
        n_checks++; if (mem_wr_last !== 1'b0) $display("FAIL reset_wr_last: got %b expected 0", mem_wr_last); else n_pass++;
        n_checks++; if (mem_rd_addr !== 32'd0) $display("FAIL reset_rd_addr: got %h expected 0", mem_rd_addr); else n_pass++;
        n_checks++; if (mem_wr_addr !== 32'd0) $display("FAIL reset_wr_addr: got %h expected 0", mem_wr_addr); else n_pass++;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_cold_load();
        access(1'b0, 4'h0, 32'h0000_1044, 32'h0, "cold_load");
        access(1'b0, 4'h0, 32'h0000_1044, 32'h0, "repeat_load");
    endtask

    task automatic test_idle();
        @(negedge clk);
        cpu_en   = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_1044;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (cpu_ready !== 1'b0 || mem_rd_req !== 1'b0)
                $display("FAIL idle_quiet: got ready=%b rd_req=%b expected 0/0", cpu_ready, mem_rd_req);
            else
                n_pass++;
            @(negedge clk);
        end
        access(1'b0, 4'h0, 32'h0000_1044, 32'h0, "post_idle_load");
    endtask

    task automatic test_store_hit();
        access(1'b1, 4'b0101, 32'h0000_1048, 32'hAABB_CCDD, "store_hit");
        access(1'b0, 4'h0, 32'h0000_1048, 32'h0, "load_after_store");
    endtask

    task automatic test_dirty_evict();
        access(1'b0, 4'h0, 32'h0002_1040, 32'h0, "dirty_evict");
    endtask

    task automatic test_wr_throttle();
        access(1'b1, 4'b1111, 32'h0002_1050, 32'h1234_5678, "dirty_again");
        wr_toggle = 1'b1;
        access(1'b0, 4'h0, 32'h0000_1044, 32'h0, "throttled_wb");
        wr_toggle = 1'b0;
        access(1'b0, 4'h0, 32'h0002_1050, 32'h0, "reload_written_back");
    endtask

    task automatic test_store_miss();
        access(1'b1, 4'b1111, 32'h0000_3000, 32'hCAFE_F00D, "store_miss");
        access(1'b0, 4'h0, 32'h0000_3000, 32'h0, "load_after_store_miss");
        access(1'b1, 4'b0000, 32'h0000_3004, 32'hFFFF_FFFF, "store_no_bytes");
    endtask

    task automatic test_reset_mid_refill();
        int cycles;
        exp_rd_addr = 32'h0000_5080;
        exp_wr_addr = {m_tag[2], 6'd2, 6'b0};
        rd_beat = 0;
        wr_beat = 0;
        cycles  = 0;
        @(negedge clk);
        cpu_en = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h0000_5080;
        while (rd_beat < 7 && cycles < 300) begin
            mem_drive();
            #1;
            mem_check();
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (rd_beat != 7)
            $display("FAIL mid_refill_reach: got %0d beats expected 7", rd_beat);
        else
            n_pass++;
        rst = 1'b0;
        cpu_en = 1'b0;
        mem_rd_valid = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (mem_rd_req !== 1'b0) $display("FAIL abort_rd_req: got %b expected 0", mem_rd_req); else n_pass++;
        n_checks++; if (mem_wr_req !== 1'b0) $display("FAIL abort_wr_req: got %b expected 0", mem_wr_req); else n_pass++;
        n_checks++; if (cpu_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", cpu_ready); else n_pass++;
        rst = 1'b1;
        model_reset();
        access(1'b0, 4'h0, 32'h0000_5080, 32'h0, "reload_after_abort");
        access(1'b0, 4'h0, 32'h0000_1044, 32'h0, "cleared_line_misses");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            a = {12'd0, 8'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            access(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, "random");
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                cpu_en = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cold_load();
        test_idle();
        test_store_hit();
        test_dirty_evict();
        test_wr_throttle();
        test_store_miss();
        test_reset_mid_refill();
        test_random();
        @(negedge clk);
        cpu_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
